struct_rr_arbiter: RTL and testbench
====================================

# struct_rr_arbiter

Round-robin arbiter sharing one parameterised-type output channel among N requesters. Each requester presents a payload of type-parameter `T` (default `struct_p`) with a valid/ready handshake. The block selects one winner per accept cycle into a single registered output stage. It sits between producer modules instantiated with a common payload type and a single shared consumer.

## Interface
- `T`, `struct_p`: payload type, any packed type.
- `N`, 4: requester count, 2..16.
- `CNT_W`, 16: width of the accepted-beat counter.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req_valid`, input, N: per-requester payload valid.
- `req_data`, input, N x `$bits(T)`: unpacked array `T req_data[N]`.
- `req_ready`, output, N: one-hot or zero; requester i beat accepted this cycle.
- `out_valid`, output, 1: output register holds a beat.
- `out_data`, output, `T`: registered payload.
- `out_src`, output, `$clog2(N)`: index of the requester that produced `out_data`.
- `out_ready`, input, 1: consumer accepts.
- `beat_cnt`, output, `CNT_W`: total beats accepted, saturating.

## Operation
- The output stage has two states. In EMPTY, `out_valid` = 0. In FULL, `out_valid` = 1.
- Accept window `acc = !out_valid || out_ready`.
- When `acc` is true and any `req_valid` is set, the winner is the first set bit searching upward from `ptr`, wrapping N-1 -> 0.
- `req_ready[winner]` = 1 combinationally in that same cycle. All other `req_ready` bits are 0, and all are 0 when `acc` is false.
- On an accept edge, the block loads `out_data` <= `req_data[winner]` and `out_src` <= winner. State goes to FULL. `ptr` <= (winner + 1) mod N. `beat_cnt` increments and saturates at all-ones.
- FULL with `out_ready` = 1 and no request: state goes to EMPTY and `out_data`/`out_src` hold their values.
- FULL with `out_ready` = 1 and a request: the block drains and refills in the same edge, staying FULL. This gives 1 beat/cycle throughput.
- FULL with `out_ready` = 0: all outputs stay stable and `req_ready` = 0.
- `ptr` is unchanged when no beat is accepted.
- The block does not inspect payload contents. `T` is transported bit-exact.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is visible on `out_*` after edge k.
- `req_ready` depends on `out_valid`, `out_ready`, `req_valid` and `ptr` only. It never depends on `req_data`.
- Reset values (async, applied while `rst_n` = 0): `out_valid` 0, `out_data` '0, `out_src` 0, `ptr` 0, `beat_cnt` 0, lock state cleared.
- Reset mid-transfer drops the held beat without it being presented. The first accept after release starts the search at requester 0.
- Fairness: with all N requesters continuously valid and `out_ready` = 1, the grant order is 0, 1, ..., N-1, 0, ...
- Requesters may drop `req_valid` without having been granted. The block places no constraint on them.

## Configuration
- `STRUCT_ARB_LOCK_EN` defined: adds input `req_lock` (N bits).
  - An accepted beat with `req_lock[winner]` = 1 sets `locked` = 1 and `lock_id` = winner.
  - While `locked` = 1, only `lock_id` is eligible, and the pointer search is bypassed.
  - Accepting a beat from `lock_id` with `req_lock` = 0 clears `locked`, and `ptr` advances normally.
- `STRUCT_ARB_LOCK_EN` undefined: no `req_lock` port and no lock state. The arbiter is pure round-robin per beat.

## Structure
- The shared package `struct_arb_pkg` holds:
  - `typedef struct packed {logic x; int y; time z;} struct_p;`
  - the default `N`
  - the `CNT_W` localparam
- Sub-module `rr_pick_mask`: combinational search, parameter N. Inputs are the request vector and `ptr`. Outputs are the one-hot grant, the encoded index and `any`.
- The top level contains the output register, the state, `ptr`, the counter and the lock logic.

## Test plan
- Single request: req 2 valid with `'{1,7,10}`, `out_ready` = 1.
  - `req_ready[2]` = 1 in the same cycle.
  - Next cycle: `out_valid` = 1, `out_data` = `'{1,7,10}`, `out_src` = 2, `beat_cnt` = 1.
- Full contention: all 4 valid with distinct `y` = 0..3, `out_ready` = 1 for 8 cycles.
  - `out_src` sequence is 0,1,2,3,0,1,2,3.
  - `beat_cnt` = 8.
- Backpressure: FULL and `out_ready` = 0 for 5 cycles.
  - `out_data` is stable and `req_ready` = 0.
  - After release, the next beat comes from `ptr` and there is no bubble.
- Reset mid-operation: assert `rst_n` = 0 while FULL with `ptr` = 3.
  - Outputs reset immediately.
  - After release with all valid, the first `out_src` = 0.
- `CNT_W` = 4 with 20 beats accepted: `beat_cnt` = 15.
- `STRUCT_ARB_LOCK_EN`, all valid, req 1 issues 3 beats with lock = 1,1,0.
  - `out_src` = 1,1,1, then 2.

Source files
------------

// File: rtl/struct_rr_arbiter_pkg.sv
// struct_arb_pkg: shared payload type, defaults and output-stage state for struct_rr_arbiter
package struct_arb_pkg;
  typedef struct packed {logic x; int y; time z;} struct_p;
  localparam int N_DEF = 4;
  localparam int CNT_W = 16;
  typedef enum logic {EMPTY, FULL} arb_state_e;
endpackage

// File: rtl/struct_rr_arbiter_if.sv
// struct_rr_arbiter_if: N requester valid/ready/payload channels plus one shared output channel and beat counter
// slave  (arbiter): in req_valid, req_data, out_ready, [req_lock]; out req_ready, out_valid, out_data, out_src, beat_cnt
// master (system):  mirror of slave
// STRUCT_ARB_LOCK_EN adds the per-requester req_lock vector
interface struct_rr_arbiter_if
  import struct_arb_pkg::*;
#(
  parameter type T = struct_p,
  parameter int N = N_DEF,
  parameter int CNT_W = struct_arb_pkg::CNT_W
);
  logic [N-1:0] req_valid;
  T req_data [N];
  logic [N-1:0] req_ready;
`ifdef STRUCT_ARB_LOCK_EN
  logic [N-1:0] req_lock;
`endif
  logic out_valid;
  T out_data;
  logic [$clog2(N)-1:0] out_src;
  logic out_ready;
  logic [CNT_W-1:0] beat_cnt;
`ifdef STRUCT_ARB_LOCK_EN
  modport slave (input req_valid, req_data, req_lock, out_ready,
                 output req_ready, out_valid, out_data, out_src, beat_cnt);
  modport master (output req_valid, req_data, req_lock, out_ready,
                  input req_ready, out_valid, out_data, out_src, beat_cnt);
`else
  modport slave (input req_valid, req_data, out_ready,
                 output req_ready, out_valid, out_data, out_src, beat_cnt);
  modport master (output req_valid, req_data, out_ready,
                  input req_ready, out_valid, out_data, out_src, beat_cnt);
`endif
endinterface

// File: rtl/struct_rr_arbiter_pick.sv
// rr_pick_mask: combinational round-robin search; first set bit of i_req at or above i_ptr, wrapping N-1 -> 0
// in i_req (N), i_ptr (clog2 N); out o_gnt one-hot, o_idx encoded winner, o_any some request present
module rr_pick_mask
  import struct_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);
  localparam int W = $clog2(N);
  logic [W-1:0] w_idx [N];
  for (genvar k = 0; k < N; k++) begin : g_idx
    assign w_idx[k] = W'((32'(i_ptr) + k) % N);
  end
  // Scan farthest offset first so the nearest requester from i_ptr overwrites and wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[w_idx[k]]) begin
        o_gnt = '0;
        o_gnt[w_idx[k]] = 1'b1;
        o_idx = w_idx[k];
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/struct_rr_arbiter.sv
// struct_rr_arbiter: N-way round-robin arbiter into one registered output stage of payload type T
// clk, rst_n (async active-low); bus (struct_rr_arbiter_if.slave): request channels, output channel, saturating beat_cnt
// STRUCT_ARB_LOCK_EN: req_lock holds the grant on one requester until it sends a beat with lock clear
module struct_rr_arbiter
  import struct_arb_pkg::*;
#(
  parameter type T = struct_p,
  parameter int N = N_DEF,
  parameter int CNT_W = struct_arb_pkg::CNT_W
) (
  input logic clk,
  input logic rst_n,
  struct_rr_arbiter_if.slave bus
);
  localparam int W = $clog2(N);
  arb_state_e r_state, w_state_nxt;
  T r_data;
  logic [W-1:0] r_src, r_ptr, w_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0] w_req, w_gnt;
  logic w_any, w_acc, w_take;
`ifdef STRUCT_ARB_LOCK_EN
  logic r_locked;
  logic [W-1:0] r_lock_id;
  assign w_req = r_locked ? (bus.req_valid & (N'(1) << r_lock_id)) : bus.req_valid;
  // A winner's lock bit decides whether the grant stays with it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_locked <= 1'b0;
      r_lock_id <= '0;
    end else if (w_take) begin
      r_locked <= bus.req_lock[w_idx];
      r_lock_id <= w_idx;
    end
`else
  assign w_req = bus.req_valid;
`endif
  rr_pick_mask #(.N(N)) u_pick (
    .i_req(w_req),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign w_acc = (r_state == EMPTY) || bus.out_ready;
  assign w_take = w_acc && w_any;
  assign bus.req_ready = w_acc ? w_gnt : '0;
  always_comb w_state_nxt = w_take ? FULL : (bus.out_ready ? EMPTY : r_state);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data <= '0;
      r_src <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_data <= bus.req_data[w_idx];
        r_src <= w_idx;
        r_ptr <= (w_idx == W'(N - 1)) ? '0 : w_idx + 1'b1;
        if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
      end
    end
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data = r_data;
  assign bus.out_src = r_src;
  assign bus.beat_cnt = r_cnt;
endmodule

// File: tb/tb_struct_rr_arbiter.sv
// tb_struct_rr_arbiter: scoreboard bench for struct_rr_arbiter (default and CNT_W=4 instances)
module tb_struct_rr_arbiter;
  import struct_arb_pkg::*;
  typedef struct {struct_p d; logic [1:0] s; logic [15:0] c;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  struct_rr_arbiter_if #(.T(struct_p), .N(4), .CNT_W(16)) bus ();
  struct_rr_arbiter_if #(.T(struct_p), .N(4), .CNT_W(4)) bs ();
  struct_rr_arbiter #(.T(struct_p), .N(4), .CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  struct_rr_arbiter #(.T(struct_p), .N(4), .CNT_W(4)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bs.slave));
  function automatic struct_p mk(input logic a, input int b, input time c);
    return '{x: a, y: b, z: c};
  endfunction
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic push(input struct_p d, input logic [1:0] s, input logic [15:0] c);
    q.push_back('{d: d, s: s, c: c});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Monitor: a beat shown with out_ready high is consumed at the next edge, so each is seen once.
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_beat", {bus.out_src, bus.out_data}, '0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_data", bus.out_data, e.d);
        chk("sb_src", bus.out_src, e.s);
        chk("sb_cnt", bus.beat_cnt, e.c);
      end
    end
  initial begin
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    bs.req_valid = '0;
    bs.out_ready = 1'b1;
`ifdef STRUCT_ARB_LOCK_EN
    bus.req_lock = '0;
    bs.req_lock = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      bus.req_data[i] = mk(1'b0, i, i * 100);
      bs.req_data[i] = mk(1'b0, i, i * 100);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_src", bus.out_src, 0);
    chk("rst_cnt", bus.beat_cnt, 0);
    chk("rst_data", bus.out_data, 0);
    rst_n = 1'b1;
    tick;
    // single request from requester 2
    bus.req_data[2] = mk(1'b1, 7, 10);
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    chk("single_ready", bus.req_ready, 4'b0100);
    push(mk(1'b1, 7, 10), 2'd2, 16'd1);
    tick;
    bus.req_valid = '0;
    bus.req_data[2] = mk(1'b0, 2, 200);
    chk("single_valid", bus.out_valid, 1);
    tick;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick;
    // full contention from ptr 0
    bus.req_valid = 4'hf;
    for (int k = 0; k < 8; k++) begin
      push(mk(1'b0, k % 4, (k % 4) * 100), 2'(k % 4), 16'(k + 1));
      tick;
    end
    bus.req_valid = '0;
    chk("contention_cnt", bus.beat_cnt, 8);
    tick;
    // backpressure
    bus.out_ready = 1'b0;
    bus.req_valid = 4'hf;
    push(mk(1'b0, 0, 0), 2'd0, 16'd9);
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_data", bus.out_data, mk(1'b0, 0, 0));
      chk("bp_valid", bus.out_valid, 1);
      tick;
    end
    bus.out_ready = 1'b1;
    push(mk(1'b0, 1, 100), 2'd1, 16'd10);
    tick;
    chk("bp_no_bubble", {bus.out_valid, bus.out_src}, {1'b1, 2'd1});
    tick;
    bus.out_ready = 1'b0;
    bus.req_valid = '0;
    chk("pre_rst_src", bus.out_src, 2);
    // reset while FULL with ptr 3
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_cnt", bus.beat_cnt, 0);
    chk("mid_rst_src", bus.out_src, 0);
    tick;
    rst_n = 1'b1;
    bus.req_valid = 4'hf;
    bus.out_ready = 1'b1;
    push(mk(1'b0, 0, 0), 2'd0, 16'd1);
    tick;
    bus.req_valid = '0;
    tick;
`ifdef STRUCT_ARB_LOCK_EN
    // ptr is 1; requester 1 holds the grant for three beats
    bus.req_valid = 4'hf;
    bus.req_lock = 4'b0010;
    push(mk(1'b0, 1, 100), 2'd1, 16'd2);
    tick;
    push(mk(1'b0, 1, 100), 2'd1, 16'd3);
    tick;
    bus.req_lock = '0;
    push(mk(1'b0, 1, 100), 2'd1, 16'd4);
    tick;
    push(mk(1'b0, 2, 200), 2'd2, 16'd5);
    tick;
    bus.req_valid = '0;
    tick;
`endif
    // saturating counter on the CNT_W=4 instance
    bs.req_valid = 4'hf;
    repeat (14) tick;
    chk("sat_cnt14", bs.beat_cnt, 14);
    repeat (6) tick;
    chk("sat_cnt20", bs.beat_cnt, 15);
    bs.req_valid = '0;
    repeat (3) tick;
    chk("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
